// File: rtl/game_pkg.sv
// Shared grid definitions for the Game-of-Life engine and its display scanner.
package game_pkg;

  localparam int GRID_DIM  = 8;
  localparam int GRID_BITS = GRID_DIM * GRID_DIM;

  typedef logic [GRID_BITS-1:0] grid_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/grid_popcount.sv
// Combinational live-cell counter for one 64-cell generation.
module grid_popcount
  import game_pkg::*;
(
  input  grid_t      grid,
  output logic [6:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < GRID_BITS; i++) begin
      count = count + 7'(grid[i]);
    end
  end

endmodule

// File: rtl/grid_display_scan.sv
// Double-buffered 8x8 LED row scanner: a new generation is swapped in only at a
// frame boundary, and each row is preceded by an all-off blanking interval.
module grid_display_scan
  import game_pkg::*;
#(
  parameter int ROW_DWELL    = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  grid_t               grid_in,
  input  logic                grid_valid,
  output logic [GRID_DIM-1:0] row_sel,
  output logic [GRID_DIM-1:0] col_data,
  output logic                frame_done,
  output logic [6:0]          alive_count
);

  localparam int CNT_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  scan_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    row_idx, row_next;
  logic          swap_edge;

  grid_t      front, back, load_val;
  logic       pending;
  logic [6:0] load_count;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    row_next   = row_idx;
    swap_edge  = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end
      end
      DRIVE: begin
        if (cnt == CW'(ROW_DWELL - 1)) begin
          state_next = BLANK;
          cnt_next   = '0;
          row_next   = row_idx + 3'd1;
          swap_edge  = (row_idx == 3'd7);
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BLANK;
      cnt     <= '0;
      row_idx <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      row_idx <= row_next;
    end
  end

  // A strobe landing on the swap edge bypasses the back buffer so the newest generation wins.
  assign load_val = grid_valid ? grid_in : back;

  grid_popcount u_popcount (
    .grid  (load_val),
    .count (load_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      front       <= '0;
      back        <= '0;
      pending     <= 1'b0;
      alive_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= swap_edge;
      if (grid_valid) begin
        back <= grid_in;
      end
      if (swap_edge) begin
        if (pending || grid_valid) begin
          front       <= load_val;
          alive_count <= load_count;
        end
        pending <= 1'b0;
      end else if (grid_valid) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    row_sel  = '0;
    col_data = '0;
    if (state == DRIVE) begin
      row_sel  = GRID_DIM'(1) << row_idx;
      col_data = front[{row_idx, 3'b000} +: GRID_DIM];
    end
  end

endmodule
